mem_arbiter: RTL and testbench

Parametrised N-channel arbiter between the memory block and its bus masters (ROM loader, command processor, ROM reader and future masters). It replaces wire-OR bus sharing and clock-gated sequencing with registered, one-at-a-time grants. Selection is fixed-priority or round-robin. A timeout counter aborts transactions the memory never answers.

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one bus master at a time to a single memory port. Outputs are registered.
// Selection is fixed-priority or round-robin. A BUSY timeout aborts transactions that memory never answers.
module mem_arbiter #(
  parameter int CHANNELS    = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          ch_request,
  input  logic [CHANNELS-1:0]          ch_mode,
  input  logic [CHANNELS*ADDR_W-1:0]   ch_locator,
  input  logic [CHANNELS*DATA_W-1:0]   ch_write,
  output logic [CHANNELS-1:0]          ch_response,
  output logic                         ch_error,
  output logic [DATA_W-1:0]            ch_read,
  output logic [CHANNELS-1:0]          grant,
  output logic                         mem_request,
  output logic                         mem_mode,
  output logic [ADDR_W-1:0]            mem_locator,
  output logic [DATA_W-1:0]            mem_write,
  input  logic [DATA_W-1:0]            mem_read,
  input  logic                         mem_response
);

  localparam int IDX_W = $clog2(CHANNELS);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t              state_reg, state_next;
  logic [CHANNELS-1:0] grant_reg, grant_next;
  logic [CHANNELS-1:0] response_reg, response_next;
  logic                error_reg, error_next;
  logic [DATA_W-1:0]   read_reg, read_next;
  logic                mem_request_reg, mem_request_next;
  logic                mem_mode_reg, mem_mode_next;
  logic [ADDR_W-1:0]   mem_locator_reg, mem_locator_next;
  logic [DATA_W-1:0]   mem_write_reg, mem_write_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [IDX_W-1:0]    last_grant_reg, last_grant_next;
  logic [IDX_W-1:0]    winner;
  logic                timeout_hit;

  logic [ADDR_W-1:0] locator_slice [CHANNELS];
  logic [DATA_W-1:0] write_slice   [CHANNELS];

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign locator_slice[gi] = ch_locator[gi*ADDR_W +: ADDR_W];
      assign write_slice[gi]   = ch_write[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan from farthest to nearest, so the closest requesting channel is the one kept.
  generate
    if (ROUND_ROBIN != 0) begin : g_rr
      always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int off = CHANNELS; off >= 1; off--) begin
          idx = (int'(last_grant_reg) + off) % CHANNELS;
          if (ch_request[IDX_W'(idx)]) winner = IDX_W'(idx);
        end
      end
    end else begin : g_fixed
      always_comb begin
        winner = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
          if (ch_request[IDX_W'(i)]) winner = IDX_W'(i);
        end
      end
    end
  endgenerate

  assign timeout_hit = (TIMEOUT > 0) && (count_reg == CNT_LAST);

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    response_next    = response_reg;
    error_next       = error_reg;
    read_next        = read_reg;
    mem_request_next = mem_request_reg;
    mem_mode_next    = mem_mode_reg;
    mem_locator_next = mem_locator_reg;
    mem_write_next   = mem_write_reg;
    count_next       = count_reg;
    last_grant_next  = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (|ch_request) begin
          grant_next       = CHANNELS'(1) << winner;
          last_grant_next  = winner;
          mem_request_next = 1'b1;
          mem_mode_next    = ch_mode[winner];
          mem_locator_next = locator_slice[winner];
          mem_write_next   = write_slice[winner];
          count_next       = '0;
          state_next       = BUSY;
        end
      end
      BUSY: begin
        // A response on the final timeout cycle still counts as a normal completion.
        if (mem_response) begin
          read_next        = mem_read;
          response_next    = grant_reg;
          error_next       = 1'b0;
          mem_request_next = 1'b0;
          state_next       = RELEASE;
        end else if (timeout_hit) begin
          read_next        = '0;
          response_next    = grant_reg;
          error_next       = 1'b1;
          mem_request_next = 1'b0;
          state_next       = RELEASE;
        end else if (TIMEOUT > 0) begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      RELEASE: begin
        response_next = '0;
        error_next    = 1'b0;
        grant_next    = '0;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      response_reg    <= '0;
      error_reg       <= 1'b0;
      read_reg        <= '0;
      mem_request_reg <= 1'b0;
      mem_mode_reg    <= 1'b0;
      mem_locator_reg <= '0;
      mem_write_reg   <= '0;
      count_reg       <= '0;
      last_grant_reg  <= IDX_W'(CHANNELS - 1);
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      response_reg    <= response_next;
      error_reg       <= error_next;
      read_reg        <= read_next;
      mem_request_reg <= mem_request_next;
      mem_mode_reg    <= mem_mode_next;
      mem_locator_reg <= mem_locator_next;
      mem_write_reg   <= mem_write_next;
      count_reg       <= count_next;
      last_grant_reg  <= last_grant_next;
    end
  end

  assign grant       = grant_reg;
  assign ch_response = response_reg;
  assign ch_error    = error_reg;
  assign ch_read     = read_reg;
  assign mem_request = mem_request_reg;
  assign mem_mode    = mem_mode_reg;
  assign mem_locator = mem_locator_reg;
  assign mem_write   = mem_write_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority instance share all inputs.
// The two instances therefore run in lockstep, and each step checks the expected outputs.
module tb_mem_arbiter;
  localparam int CH  = 3;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CH-1:0]    ch_request = '0;
  logic [CH-1:0]    ch_mode = '0;
  logic [CH*AW-1:0] ch_locator = '0;
  logic [CH*DW-1:0] ch_write = '0;
  logic [DW-1:0]    mem_read = '0;
  logic             mem_response = 1'b0;

  logic [CH-1:0] ch_response, grant;
  logic          ch_error, mem_request, mem_mode;
  logic [DW-1:0] ch_read, mem_write;
  logic [AW-1:0] mem_locator;

  logic [CH-1:0] ch_response_fp, grant_fp;
  logic          ch_error_fp, mem_request_fp, mem_mode_fp;
  logic [DW-1:0] ch_read_fp, mem_write_fp;
  logic [AW-1:0] mem_locator_fp;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1), .TIMEOUT(TMO)) dut_rr (
    .clk(clk), .rst_n(rst_n), .ch_request(ch_request), .ch_mode(ch_mode),
    .ch_locator(ch_locator), .ch_write(ch_write), .ch_response(ch_response),
    .ch_error(ch_error), .ch_read(ch_read), .grant(grant), .mem_request(mem_request),
    .mem_mode(mem_mode), .mem_locator(mem_locator), .mem_write(mem_write),
    .mem_read(mem_read), .mem_response(mem_response)
  );

  mem_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(0), .TIMEOUT(TMO)) dut_fp (
    .clk(clk), .rst_n(rst_n), .ch_request(ch_request), .ch_mode(ch_mode),
    .ch_locator(ch_locator), .ch_write(ch_write), .ch_response(ch_response_fp),
    .ch_error(ch_error_fp), .ch_read(ch_read_fp), .grant(grant_fp), .mem_request(mem_request_fp),
    .mem_mode(mem_mode_fp), .mem_locator(mem_locator_fp), .mem_write(mem_write_fp),
    .mem_read(mem_read), .mem_response(mem_response)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic mode, input logic [AW-1:0] loc, input logic [DW-1:0] data);
    ch_mode[i]            = mode;
    ch_locator[i*AW +: AW] = loc;
    ch_write[i*DW +: DW]   = data;
  endtask

  task automatic show(input string name);
    $display("txn %s grant=%b resp=%b err=%b read=%h", name, grant, ch_response, ch_error, ch_read);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_grant", grant, 0);
    chk("rst_mem_request", mem_request, 0);
    chk("rst_ch_response", ch_response, 0);
    chk("rst_ch_read", ch_read, 0);
    chk("rst_mem_locator", mem_locator, 0);
    rst_n = 1'b1;

    // Round-robin, every channel dropping its request on its own response
    for (int i = 0; i < CH; i++) set_ch(i, 1'b0, 16'h0100 + 16'(i), 16'h0);
    ch_request = 3'b111;
    for (int i = 0; i < CH; i++) begin
      tick();
      chk("rr_drop_grant", grant, 32'd1 << i);
      chk("rr_drop_locator", mem_locator, 32'h0100 + i);
      mem_response = 1'b1;
      mem_read     = 16'hA000 + 16'(i);
      tick();
      chk("rr_drop_response", ch_response, 32'd1 << i);
      chk("rr_drop_read", ch_read, 32'hA000 + i);
      show("rr_drop");
      ch_request[i] = 1'b0;
      mem_response  = 1'b0;
      tick();
    end

    // All requests held: round-robin rotates, fixed priority always picks channel 0
    ch_request = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_hold_grant", grant, 32'd1 << (i % 3));
      chk("fp_hold_grant", grant_fp, 32'd1);
      mem_response = 1'b1;
      mem_read     = 16'hB000 + 16'(i);
      tick();
      chk("rr_hold_response", ch_response, 32'd1 << (i % 3));
      chk("fp_hold_response", ch_response_fp, 32'd1);
      show("rr_hold");
      mem_response = 1'b0;
      tick();
    end
    ch_request = 3'b000;

    // Single read on channel 1
    set_ch(1, 1'b0, 16'h0040, 16'h0);
    ch_request = 3'b010;
    tick();
    chk("single_grant", grant, 3'b010);
    chk("single_mem_request", mem_request, 1);
    chk("single_locator", mem_locator, 16'h0040);
    chk("single_mode", mem_mode, 0);
    tick();
    tick();
    chk("single_busy_response", ch_response, 0);
    mem_response = 1'b1;
    mem_read     = 16'hBEEF;
    tick();
    chk("single_response", ch_response, 3'b010);
    chk("single_read", ch_read, 16'hBEEF);
    chk("single_error", ch_error, 0);
    chk("single_mem_request_low", mem_request, 0);
    show("single_read");
    ch_request   = 3'b000;
    mem_response = 1'b0;
    tick();
    chk("single_response_pulse", ch_response, 0);
    chk("single_grant_clear", grant, 0);
    chk("single_read_hold", ch_read, 16'hBEEF);

    // Memory response while idle is ignored
    mem_response = 1'b1;
    mem_read     = 16'h1111;
    tick();
    chk("idle_resp_ignored", ch_response, 0);
    chk("idle_read_hold", ch_read, 16'hBEEF);
    mem_response = 1'b0;
    tick();

    // Write isolation: slices change during BUSY, memory side stays latched
    set_ch(0, 1'b1, 16'h0010, 16'h1234);
    ch_request = 3'b001;
    tick();
    chk("wr_grant", grant, 3'b001);
    chk("wr_mode", mem_mode, 1);
    chk("wr_locator", mem_locator, 16'h0010);
    chk("wr_data", mem_write, 16'h1234);
    set_ch(2, 1'b0, 16'hFFFF, 16'hDEAD);
    set_ch(0, 1'b0, 16'h0077, 16'h7777);
    tick();
    tick();
    chk("wr_locator_held", mem_locator, 16'h0010);
    chk("wr_data_held", mem_write, 16'h1234);
    chk("wr_mode_held", mem_mode, 1);
    mem_response = 1'b1;
    mem_read     = 16'h5A5A;
    tick();
    chk("wr_response", ch_response, 3'b001);
    chk("wr_mem_request_low", mem_request, 0);
    show("write");
    ch_request   = 3'b000;
    mem_response = 1'b0;
    tick();

    // Timeout on channel 1 with channel 2 waiting
    set_ch(1, 1'b0, 16'h0200, 16'h0);
    set_ch(2, 1'b0, 16'h0300, 16'h0);
    ch_request = 3'b110;
    tick();
    chk("tmo_grant", grant, 3'b010);
    for (int j = 1; j < TMO; j++) begin
      tick();
      chk("tmo_early_response", ch_response, 0);
      chk("tmo_early_mem_request", mem_request, 1);
    end
    tick();
    chk("tmo_response", ch_response, 3'b010);
    chk("tmo_error", ch_error, 1);
    chk("tmo_read", ch_read, 0);
    chk("tmo_mem_request", mem_request, 0);
    show("timeout");
    ch_request[1] = 1'b0;
    tick();
    chk("tmo_error_clear", ch_error, 0);
    chk("tmo_grant_clear", grant, 0);
    tick();
    chk("tmo_next_grant", grant, 3'b100);
    chk("tmo_next_locator", mem_locator, 16'h0300);
    mem_response = 1'b1;
    mem_read     = 16'h3333;
    tick();
    chk("tmo_next_response", ch_response, 3'b100);
    chk("tmo_next_error", ch_error, 0);
    chk("tmo_next_read", ch_read, 16'h3333);
    show("after_timeout");
    ch_request   = 3'b000;
    mem_response = 1'b0;
    tick();

    // Response on the same cycle the counter reaches the limit
    set_ch(0, 1'b0, 16'h0400, 16'h0);
    ch_request = 3'b001;
    tick();
    chk("sim_grant", grant, 3'b001);
    repeat (TMO - 1) tick();
    mem_response = 1'b1;
    mem_read     = 16'hCAFE;
    tick();
    chk("sim_response", ch_response, 3'b001);
    chk("sim_error", ch_error, 0);
    chk("sim_read", ch_read, 16'hCAFE);
    show("simultaneous");
    ch_request   = 3'b000;
    mem_response = 1'b0;
    tick();

    // Asynchronous reset in the middle of BUSY
    set_ch(1, 1'b1, 16'h0500, 16'h5555);
    ch_request = 3'b010;
    tick();
    chk("rstb_grant", grant, 3'b010);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstb_grant_zero", grant, 0);
    chk("rstb_mem_request", mem_request, 0);
    chk("rstb_mem_locator", mem_locator, 0);
    chk("rstb_mem_write", mem_write, 0);
    chk("rstb_mem_mode", mem_mode, 0);
    chk("rstb_ch_read", ch_read, 0);
    ch_request = 3'b111;
    tick();
    chk("rstb_no_response", ch_response, 0);
    rst_n = 1'b1;
    tick();
    chk("rstb_first_grant", grant, 3'b001);
    mem_response = 1'b1;
    mem_read     = 16'h4444;
    tick();
    chk("rstb_response", ch_response, 3'b001);
    show("after_reset");
    ch_request   = 3'b000;
    mem_response = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
